// File: rtl/datapath_pkg.sv
// Shared datapath widths and EX/MEM payload layout.
package datapath_pkg;

    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_REG_ADDR_W = 5;
    localparam int unsigned CTRL_W         = 6;

    typedef struct packed {
        logic jump;
        logic branch;
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic reg_write;
    } ex_mem_ctrl_t;

    typedef struct packed {
        ex_mem_ctrl_t                ctrl;
        logic [DEF_DATA_W-1:0]       next_pc;
        logic                        zf;
        logic [DEF_DATA_W-1:0]       alu_result;
        logic [DEF_DATA_W-1:0]       read_data2;
        logic [DEF_REG_ADDR_W-1:0]   write_reg;
    } ex_mem_payload_t;

    // Flat payload width for non-default widths; field order matches ex_mem_payload_t.
    function automatic int unsigned payload_w(input int unsigned dw, input int unsigned aw);
        return CTRL_W + 3 * dw + 1 + aw;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// Generic valid/ready register slice with synchronous flush and optional skid slot.
module pipe_skid_slot #(
    parameter int unsigned W    = 8,
    parameter bit          SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q, main_valid_d;
    logic [W-1:0] main_q, main_d;
    logic         accept;
    logic         emit;

    assign accept    = in_valid & in_ready;
    assign emit      = main_valid_q & out_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

    generate
        if (SKID) begin : g_skid
            logic         skid_valid_q, skid_valid_d;
            logic [W-1:0] skid_q, skid_d;
            logic         in_ready_q;

            // MAIN refills from SKID first so arrival order is preserved.
            always_comb begin
                main_valid_d = main_valid_q;
                main_d       = main_q;
                skid_valid_d = skid_valid_q;
                skid_d       = skid_q;
                if (flush) begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end else if (emit || !main_valid_q) begin
                    if (skid_valid_q) begin
                        main_d       = skid_q;
                        main_valid_d = 1'b1;
                        skid_valid_d = 1'b0;
                    end else if (accept) begin
                        main_d       = in_data;
                        main_valid_d = 1'b1;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end else if (accept) begin
                    skid_d       = in_data;
                    skid_valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skid_valid_q <= 1'b0;
                    skid_q       <= '0;
                    in_ready_q   <= 1'b1;
                end else begin
                    skid_valid_q <= skid_valid_d;
                    skid_q       <= skid_d;
                    in_ready_q   <= ~skid_valid_d;
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_single
            assign in_ready = out_ready | ~main_valid_q;

            always_comb begin
                main_valid_d = main_valid_q;
                main_d       = main_q;
                if (flush) begin
                    main_valid_d = 1'b0;
                end else if (accept) begin
                    main_d       = in_data;
                    main_valid_d = 1'b1;
                end else if (emit) begin
                    main_valid_d = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline register: packs the EX fields into one payload carried by a handshake slot.
module ex_mem_pipe_stage
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter bit          SKID       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_jump,
    input  logic                  in_branch,
    input  logic                  in_mem_read,
    input  logic                  in_mem_to_reg,
    input  logic                  in_mem_write,
    input  logic                  in_reg_write,
    input  logic [DATA_W-1:0]     in_next_pc,
    input  logic                  in_zf,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_read_data2,
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_jump,
    output logic                  out_branch,
    output logic                  out_mem_read,
    output logic                  out_mem_to_reg,
    output logic                  out_mem_write,
    output logic                  out_reg_write,
    output logic [DATA_W-1:0]     out_next_pc,
    output logic                  out_zf,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_read_data2,
    output logic [REG_ADDR_W-1:0] out_write_reg
);

    localparam int unsigned PW = payload_w(DATA_W, REG_ADDR_W);

    ex_mem_ctrl_t  in_ctrl;
    ex_mem_ctrl_t  out_ctrl;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload;

    assign in_ctrl = '{jump:       in_jump,
                       branch:     in_branch,
                       mem_read:   in_mem_read,
                       mem_to_reg: in_mem_to_reg,
                       mem_write:  in_mem_write,
                       reg_write:  in_reg_write};

    assign in_payload = {in_ctrl, in_next_pc, in_zf, in_alu_result, in_read_data2, in_write_reg};
    assign {out_ctrl, out_next_pc, out_zf, out_alu_result, out_read_data2, out_write_reg} = out_payload;

    pipe_skid_slot #(
        .W    (PW),
        .SKID (SKID)
    ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    // Bubbles must never carry live control; gate with the registered valid.
    assign out_jump       = out_ctrl.jump       & out_valid;
    assign out_branch     = out_ctrl.branch     & out_valid;
    assign out_mem_read   = out_ctrl.mem_read   & out_valid;
    assign out_mem_to_reg = out_ctrl.mem_to_reg & out_valid;
    assign out_mem_write  = out_ctrl.mem_write  & out_valid;
    assign out_reg_write  = out_ctrl.reg_write  & out_valid;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: one SKID=0 and one SKID=1 instance fed the same stimulus, each checked against a FIFO model.
module tb_ex_mem_pipe_stage;
    import datapath_pkg::*;

    localparam int unsigned DW = DEF_DATA_W;
    localparam int unsigned AW = DEF_REG_ADDR_W;
    localparam int unsigned VW = $bits(ex_mem_payload_t) + 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    ex_mem_payload_t in_p = '0;

    logic          i_ready [2];
    logic          o_valid [2];
    logic          o_jump [2], o_branch [2], o_mread [2], o_m2r [2], o_mwrite [2], o_rw [2];
    logic [DW-1:0] o_npc [2], o_alu [2], o_rd2 [2];
    logic          o_zf [2];
    logic [AW-1:0] o_wreg [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: each stage is a FIFO of depth 1 (SKID=0) or 2 (SKID=1).
    ex_mem_payload_t q0 [$];
    ex_mem_payload_t q1 [$];
    ex_mem_payload_t last0 = '0;
    ex_mem_payload_t last1 = '0;
    ex_mem_payload_t pend_p;
    bit acc0, acc1, em0, em1, pend_fl;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ex_mem_pipe_stage #(
            .DATA_W     (DW),
            .REG_ADDR_W (AW),
            .SKID       (1'(g))
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .flush          (flush),
            .in_valid       (in_valid),
            .in_ready       (i_ready[g]),
            .in_jump        (in_p.ctrl.jump),
            .in_branch      (in_p.ctrl.branch),
            .in_mem_read    (in_p.ctrl.mem_read),
            .in_mem_to_reg  (in_p.ctrl.mem_to_reg),
            .in_mem_write   (in_p.ctrl.mem_write),
            .in_reg_write   (in_p.ctrl.reg_write),
            .in_next_pc     (in_p.next_pc),
            .in_zf          (in_p.zf),
            .in_alu_result  (in_p.alu_result),
            .in_read_data2  (in_p.read_data2),
            .in_write_reg   (in_p.write_reg),
            .out_valid      (o_valid[g]),
            .out_ready      (out_ready),
            .out_jump       (o_jump[g]),
            .out_branch     (o_branch[g]),
            .out_mem_read   (o_mread[g]),
            .out_mem_to_reg (o_m2r[g]),
            .out_mem_write  (o_mwrite[g]),
            .out_reg_write  (o_rw[g]),
            .out_next_pc    (o_npc[g]),
            .out_zf         (o_zf[g]),
            .out_alu_result (o_alu[g]),
            .out_read_data2 (o_rd2[g]),
            .out_write_reg  (o_wreg[g])
        );
    end

    function automatic ex_mem_payload_t mk(input logic [7:0] v, input logic rw, input logic mw);
        ex_mem_payload_t p;
        p                 = '0;
        p.ctrl.reg_write  = rw;
        p.ctrl.mem_write  = mw;
        p.ctrl.mem_read   = v[0];
        p.next_pc         = 32'(v) + 32'd4;
        p.zf              = (v == 8'd0);
        p.alu_result      = 32'(v);
        p.read_data2      = ~32'(v);
        p.write_reg       = 5'(v);
        return p;
    endfunction

    function automatic ex_mem_payload_t rnd_payload();
        ex_mem_payload_t p;
        p.ctrl       = ex_mem_ctrl_t'(6'($urandom));
        p.next_pc    = $urandom;
        p.zf         = 1'($urandom);
        p.alu_result = $urandom;
        p.read_data2 = $urandom;
        p.write_reg  = 5'($urandom);
        return p;
    endfunction

    function automatic ex_mem_payload_t act_payload(input int i);
        ex_mem_payload_t p;
        p.ctrl.jump       = o_jump[i];
        p.ctrl.branch     = o_branch[i];
        p.ctrl.mem_read   = o_mread[i];
        p.ctrl.mem_to_reg = o_m2r[i];
        p.ctrl.mem_write  = o_mwrite[i];
        p.ctrl.reg_write  = o_rw[i];
        p.next_pc         = o_npc[i];
        p.zf              = o_zf[i];
        p.alu_result      = o_alu[i];
        p.read_data2      = o_rd2[i];
        p.write_reg       = o_wreg[i];
        return p;
    endfunction

    task automatic cmp(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        ex_mem_payload_t e;
        bit              r;
        e = (q0.size() > 0) ? q0[0] : last0;
        if (q0.size() == 0) e.ctrl = '0;
        r = out_ready || (q0.size() == 0);
        cmp("skid0_outputs", {i_ready[0], o_valid[0], act_payload(0)}, {r, q0.size() > 0, e});
        e = (q1.size() > 0) ? q1[0] : last1;
        if (q1.size() == 0) e.ctrl = '0;
        r = (q1.size() < 2);
        cmp("skid1_outputs", {i_ready[1], o_valid[1], act_payload(1)}, {r, q1.size() > 0, e});
    endtask

    task automatic drive(input bit iv, input bit ordy, input bit fl, input ex_mem_payload_t p);
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_p      = p;
        #1;
        check_model();
        acc0    = iv && (ordy || q0.size() == 0);
        acc1    = iv && (q1.size() < 2);
        em0     = ordy && q0.size() > 0;
        em1     = ordy && q1.size() > 0;
        pend_fl = fl;
        pend_p  = p;
    endtask

    task automatic advance();
        @(posedge clk);
        if (pend_fl) begin
            q0.delete();
            q1.delete();
        end else begin
            if (em0) void'(q0.pop_front());
            if (acc0) q0.push_back(pend_p);
            if (em1) void'(q1.pop_front());
            if (acc1) q1.push_back(pend_p);
        end
        if (q0.size() > 0) last0 = q0[0];
        if (q1.size() > 0) last1 = q1[0];
    endtask

    typedef struct {
        bit         iv;
        bit         ordy;
        logic [7:0] v;
        bit         ov1;
        bit         ir1;
        bit         ir0;
        logic [7:0] alu1;
        bit         rw1;
    } row_t;

    row_t tbl [18];

    initial begin
        // single beat, 8-beat stream, then backpressure A/B/C with out_ready low
        tbl[0]  = '{1, 1, 8'h10, 0, 1, 1, 8'h00, 0};
        tbl[1]  = '{0, 1, 8'hEE, 1, 1, 1, 8'h10, 1};
        tbl[2]  = '{0, 1, 8'hEE, 0, 1, 1, 8'h10, 0};
        tbl[3]  = '{1, 1, 8'h01, 0, 1, 1, 8'h10, 0};
        for (int k = 4; k <= 10; k++)
            tbl[k] = '{1, 1, 8'(k - 2), 1, 1, 1, 8'(k - 3), 1};
        tbl[11] = '{0, 1, 8'hEE, 1, 1, 1, 8'h08, 1};
        tbl[12] = '{1, 0, 8'h0A, 0, 1, 1, 8'h08, 0};
        tbl[13] = '{1, 0, 8'h0B, 1, 1, 0, 8'h0A, 1};
        tbl[14] = '{1, 0, 8'h0C, 1, 0, 0, 8'h0A, 1};
        tbl[15] = '{0, 1, 8'hEE, 1, 0, 1, 8'h0A, 1};
        tbl[16] = '{0, 1, 8'hEE, 1, 1, 1, 8'h0B, 1};
        tbl[17] = '{0, 1, 8'hEE, 0, 1, 1, 8'h0B, 0};

        repeat (2) @(negedge clk);
        #1;
        cmp("reset_state", VW'({i_ready[0], i_ready[1], o_valid[0], o_valid[1], o_rw[0], o_rw[1], o_alu[1]}),
            VW'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0}));
        rst_n = 1'b1;

        for (int r = 0; r < 18; r++) begin
            drive(tbl[r].iv, tbl[r].ordy, 1'b0, mk(tbl[r].v, 1'b1, 1'b0));
            cmp($sformatf("table_row%0d", r),
                VW'({o_valid[1], i_ready[1], i_ready[0], o_alu[1], o_rw[1]}),
                VW'({tbl[r].ov1, tbl[r].ir1, tbl[r].ir0, 32'(tbl[r].alu1), tbl[r].rw1}));
            advance();
        end

        // flush with two held beats and a concurrent accept
        drive(1'b1, 1'b0, 1'b0, mk(8'h21, 1'b0, 1'b1)); advance();
        drive(1'b1, 1'b0, 1'b0, mk(8'h22, 1'b0, 1'b1)); advance();
        drive(1'b1, 1'b0, 1'b1, mk(8'h23, 1'b0, 1'b1));
        cmp("pre_flush_held", VW'({o_valid[1], o_mwrite[1], i_ready[1], o_alu[1]}),
            VW'({1'b1, 1'b1, 1'b0, 32'h21}));
        advance();
        drive(1'b0, 1'b1, 1'b0, mk(8'hEE, 1'b1, 1'b1));
        cmp("post_flush", VW'({o_valid[1], o_mwrite[1], i_ready[1], o_valid[0], o_mwrite[0], i_ready[0]}),
            VW'(6'b001001));
        advance();
        repeat (3) begin drive(1'b0, 1'b1, 1'b0, mk(8'hEE, 1'b1, 1'b1)); advance(); end

        // asynchronous reset while a beat is held
        drive(1'b1, 1'b0, 1'b0, mk(8'h30, 1'b1, 1'b1)); advance();
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        cmp("async_reset", VW'({o_valid[0], o_valid[1], o_rw[0], o_rw[1], o_mwrite[0], o_mwrite[1], i_ready[1], o_alu[1]}),
            VW'({7'b0000001, 32'd0}));
        q0.delete(); q1.delete();
        last0 = '0; last1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin drive(1'b0, 1'b1, 1'b0, rnd_payload()); advance(); end

        // randomized traffic against the FIFO model
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0), rnd_payload());
            advance();
        end
        repeat (3) begin drive(1'b0, 1'b1, 1'b0, rnd_payload()); advance(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_stage.md
Name: ex_mem_pipe_stage

Overview:
Parametrised EX/MEM pipeline register for the datapath. It replaces the free-running stage latch with a valid/ready handshake, synchronous flush, asynchronous reset and an optional skid slot. It sits between the ALU (EX) and data-memory (MEM) stages. It carries the control bits, next-instruction address, zero flag, ALU result, store data and destination register.

Parameters:
DATA_W, 32, width of next_pc, alu_result, read_data2
REG_ADDR_W, 5, width of write_reg
SKID, 1, 1 = two-slot skid buffer with registered in_ready; 0 = single slot with combinational in_ready

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held beats (branch/jump redirect)
in_valid  input  1  EX beat present
in_ready  output  1  stage can accept a beat
in_jump, in_branch, in_mem_read, in_mem_to_reg, in_mem_write, in_reg_write  input  1 each  control bits
in_next_pc  input  DATA_W  next-instruction address
in_zf  input  1  ALU zero flag
in_alu_result  input  DATA_W  ALU result / memory address
in_read_data2  input  DATA_W  store data
in_write_reg  input  REG_ADDR_W  destination register
out_valid  output  1  MEM beat present
out_ready  input  1  MEM stage consumes beat
out_jump … out_write_reg  output  same widths as inputs  registered copies

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0; skid empty; all out_* data and control = 0; in_ready=1. The first accept can occur on the first rising edge after rst_n deasserts.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready. Beats leave in arrival order. No beat is duplicated or dropped except by flush.
- Latency: a beat accepted at edge N is on out_* with out_valid=1 after edge N, i.e. usable in cycle N+1.
- Outputs come directly from flops. No combinational path from in_* data to out_*.
- Bubble rule: whenever out_valid=0, all six out control bits read 0. Data fields hold their last value.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - Main slot loads on accept; out_valid clears on emit without accept.
- SKID=1:
  - Slots are MAIN (drives out_*) and SKID. in_ready = ~skid_valid, registered.
  - Accept while MAIN is empty, or MAIN is emitting: the beat goes to MAIN.
  - Accept while MAIN is full and not emitting: the beat goes to SKID; in_ready falls on the next cycle.
  - Emit while SKID is full: SKID moves to MAIN; in_ready rises on the next cycle.
  - Full throughput: 1 beat/cycle sustained with out_ready=1.
- Flush (sampled at edge, priority over everything except reset):
  - Clears out_valid and skid_valid, and forces the out control bits to 0.
  - A beat accepted in the flush cycle is discarded.
  - in_ready is 1 in the cycle after the flush.
- Simultaneous accept and emit with one beat held: the new beat replaces it in MAIN with no bubble.
- Reset asserted mid-stream: all state is lost immediately. No beat is emitted until a new accept.
- in_* values when in_valid=0 are don't-care and must never reach out_*.

Decomposition:
- datapath_pkg: DATA_W/REG_ADDR_W defaults and a packed ex_mem_ctrl_t struct {jump, branch, mem_read, mem_to_reg, mem_write, reg_write}.
- Also in datapath_pkg: a packed ex_mem_payload_t concatenating ctrl, next_pc, zf, alu_result, read_data2, write_reg.
- One sub-module is natural: pipe_skid_slot. It is a generic payload-width register with valid/ready, flush and SKID mode.
- ex_mem_pipe_stage packs and unpacks the fields, instantiates pipe_skid_slot, and applies the bubble rule on control.

Test Plan:
- Reset then single beat: alu_result=0x0000_0010, write_reg=5, reg_write=1, out_ready=1 -> out_valid=1 one cycle later with identical fields; next cycle out_valid=0 and controls 0.
- Streaming: 8 beats back-to-back (alu_result 1..8), out_ready=1 -> outputs 1..8 on consecutive cycles; in_ready constantly 1.
- Backpressure, SKID=1: out_ready=0 while sending beats A, B -> A held on out_*, B in skid, in_ready=0 from next cycle. Raise out_ready -> A, then B, in order; in_ready returns 1 after B moves to MAIN.
- Flush: two beats held (mem_write=1), flush=1 with in_valid=1 -> next cycle out_valid=0, out_mem_write=0, in_ready=1; the flushed and concurrent beats never appear.
- Async reset mid-stream: drop rst_n between edges while a beat is held -> out_valid and controls go 0 without a clock edge.
- SKID=0 build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. Raise out_ready and drive in_valid -> the replacement beat appears next cycle with no bubble.
